// File: rtl/uart_cmd_decoder.sv
// Host command parser for the masked 2D filter: decodes h/w/n/r/m/s commands from UART bytes
// and holds the committed configuration. Optional argument timeout under `CMD_TIMEOUT_EN.
module uart_cmd_decoder #(
  parameter int MAX_N  = 7,
  parameter int MASK_W = MAX_N * MAX_N
`ifdef CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              busy,
  output logic [7:0]        height_o,
  output logic [7:0]        width_o,
  output logic [3:0]        n_o,
  output logic [7:0]        rank_o,
  output logic [MASK_W-1:0] mask_o,
  output logic              start_o,
  output logic              err_o,
  output logic              idle_o
);

  localparam int NBYTES = (MASK_W + 7) / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {IDLE, GET_H, GET_W, GET_N, GET_R, GET_MASK} state_t;

  state_t            r_state, w_state_next;
  logic [7:0]        r_height, w_height_next;
  logic [7:0]        r_width, w_width_next;
  logic [3:0]        r_n, w_n_next;
  logic [7:0]        r_rank, w_rank_next;
  logic [MASK_W-1:0] r_mask, w_mask_next;
  logic [MASK_W-1:0] r_shadow, w_shadow_next;
  logic [CNT_W-1:0]  r_byte_cnt, w_byte_cnt_next;
  logic              r_start, w_start_next;
  logic              r_err, w_err_next;
  logic              r_idle;
  logic              w_clr_shadow;
  logic              w_tmo_hit;

  logic [7:0]        w_n8, w_nn, w_nbytes;
  logic              w_last_byte, w_n_ok, w_start_ok;
  logic [MASK_W-1:0] w_keep;

  assign w_n8        = {4'b0000, r_n};
  assign w_nn        = w_n8 * w_n8;
  assign w_nbytes    = (w_nn + 8'd7) >> 3;
  assign w_last_byte = (8'(r_byte_cnt) == (w_nbytes - 8'd1));
  assign w_n_ok      = rx_data[0] && (rx_data <= 8'(MAX_N));
  assign w_start_ok  = !busy && (r_rank != 8'd0) && (r_rank <= w_nn) &&
                       (r_height >= w_n8) && (r_width >= w_n8);

  // Shadow byte lanes; the top lane is clipped when MASK_W is not a multiple of 8.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      localparam int LO = 8 * gi;
      localparam int HI = (8 * gi + 7 < MASK_W) ? 8 * gi + 7 : MASK_W - 1;
      assign w_shadow_next[HI:LO] =
        (r_state == GET_MASK && rx_valid && r_byte_cnt == CNT_W'(gi)) ?
        rx_data[HI-LO:0] : r_shadow[HI:LO];
    end
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_keep
      assign w_keep[gi] = (8'(gi) < w_nn);
    end
  endgenerate

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  assign w_tmo_hit = (r_state != IDLE) && !rx_valid && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == IDLE || rx_valid || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_height_next   = r_height;
    w_width_next    = r_width;
    w_n_next        = r_n;
    w_rank_next     = r_rank;
    w_mask_next     = r_mask;
    w_byte_cnt_next = r_byte_cnt;
    w_start_next    = 1'b0;
    w_err_next      = 1'b0;
    w_clr_shadow    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            "h": w_state_next = GET_H;
            "w": w_state_next = GET_W;
            "n": w_state_next = GET_N;
            "r": w_state_next = GET_R;
            "m": begin
              w_state_next    = GET_MASK;
              w_byte_cnt_next = '0;
              w_clr_shadow    = 1'b1;
            end
            "s": begin
              w_start_next = w_start_ok;
              w_err_next   = !w_start_ok;
            end
            default: w_err_next = 1'b1;
          endcase
        end
      end
      GET_H: if (rx_valid) begin
        w_height_next = rx_data;
        w_state_next  = IDLE;
      end
      GET_W: if (rx_valid) begin
        w_width_next = rx_data;
        w_state_next = IDLE;
      end
      GET_R: if (rx_valid) begin
        w_rank_next  = rx_data;
        w_state_next = IDLE;
      end
      GET_N: if (rx_valid) begin
        if (w_n_ok) w_n_next = rx_data[3:0];
        else        w_err_next = 1'b1;
        w_state_next = IDLE;
      end
      GET_MASK: if (rx_valid) begin
        if (w_last_byte) begin
          w_mask_next  = w_shadow_next & w_keep;
          w_state_next = IDLE;
        end else begin
          w_byte_cnt_next = r_byte_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    // A timeout can only fire on a cycle without a byte, so nothing commits alongside it.
    if (w_tmo_hit) begin
      w_state_next = IDLE;
      w_err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_height   <= 8'd0;
      r_width    <= 8'd0;
      r_n        <= 4'd3;
      r_rank     <= 8'd5;
      r_mask     <= MASK_W'(9'h1FF);
      r_shadow   <= '0;
      r_byte_cnt <= '0;
      r_start    <= 1'b0;
      r_err      <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_height   <= w_height_next;
      r_width    <= w_width_next;
      r_n        <= w_n_next;
      r_rank     <= w_rank_next;
      r_mask     <= w_mask_next;
      r_shadow   <= w_clr_shadow ? '0 : w_shadow_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_start    <= w_start_next;
      r_err      <= w_err_next;
      r_idle     <= (w_state_next == IDLE);
    end
  end

  assign height_o = r_height;
  assign width_o  = r_width;
  assign n_o      = r_n;
  assign rank_o   = r_rank;
  assign mask_o   = r_mask;
  assign start_o  = r_start;
  assign err_o    = r_err;
  assign idle_o   = r_idle;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected start/err pulses with their
// cycle, a negedge monitor pops and compares; configuration registers are checked directly.
module tb_uart_cmd_decoder;

  localparam int MASK_W = 49;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              busy = 1'b0;
  logic [7:0]        height_o, width_o, rank_o;
  logic [3:0]        n_o;
  logic [MASK_W-1:0] mask_o;
  logic              start_o, err_o, idle_o;

  uart_cmd_decoder #(
    .MAX_N(7),
    .MASK_W(MASK_W)
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .height_o(height_o), .width_o(width_o), .n_o(n_o), .rank_o(rank_o),
    .mask_o(mask_o), .start_o(start_o), .err_o(err_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = start pulse, 2 = err pulse, 3 = both (never legal)
  typedef struct { int kind; int at; } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [7:0] b, input int kind);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (kind != 0) sb_q.push_back('{kind, cyc});
  endtask

  always @(negedge clk) begin
    if (!rst && (start_o || err_o)) begin
      int act_kind;
      exp_t e;
      act_kind = (start_o ? 1 : 0) + (err_o ? 2 : 0);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL pulse_unexpected: got kind %0d at cycle %0d, expected no pulse", act_kind, cyc);
      end else begin
        e = sb_q.pop_front();
        if (act_kind != e.kind || cyc != e.at) begin
          n_bad++;
          $display("FAIL pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                   act_kind, cyc, e.kind, e.at);
        end else begin
          $display("pulse kind %0d at cycle %0d ok", act_kind, cyc);
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_height"}, 64'(height_o), 64'd0);
    check({tag, "_width"},  64'(width_o),  64'd0);
    check({tag, "_n"},      64'(n_o),      64'd3);
    check({tag, "_rank"},   64'(rank_o),   64'd5);
    check({tag, "_mask"},   64'(mask_o),   64'h1FF);
    check({tag, "_start"},  64'(start_o),  64'd0);
    check({tag, "_err"},    64'(err_o),    64'd0);
    check({tag, "_idle"},   64'(idle_o),   64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("rst");

    // Full configuration then start
    send("h", 0); send(8'd22, 0); send("w", 0); send(8'd22, 0);
    send("n", 0); send(8'd3, 0);  send("r", 0); send(8'd5, 0);
    send("m", 0); send(8'hFF, 0); send(8'h01, 0);
    send("s", 1);
    check("cfg_height", 64'(height_o), 64'd22);
    check("cfg_width",  64'(width_o),  64'd22);
    check("cfg_n",      64'(n_o),      64'd3);
    check("cfg_rank",   64'(rank_o),   64'd5);
    check("cfg_mask",   64'(mask_o),   64'h1FF);

    // Illegal window sizes rejected, n=7 accepted, 7-byte mask
    send("n", 0); send(8'd4, 2);
    send("n", 0); send(8'd9, 2);
    check("n_unchanged", 64'(n_o), 64'd3);
    send("n", 0); send(8'd7, 0);
    check("n7", 64'(n_o), 64'd7);
    send("m", 0);
    for (int i = 0; i < 7; i++) begin
      send(8'hFF, 0);
      check($sformatf("mask7_idle_b%0d", i), 64'(idle_o), (i == 6) ? 64'd1 : 64'd0);
    end
    check("mask49", 64'(mask_o), 64'h1_FFFF_FFFF_FFFF);

    // Rank bound against n*n
    send("n", 0); send(8'd5, 0);
    send("r", 0); send(8'd26, 0); send("s", 2);
    send("r", 0); send(8'd25, 0); send("s", 1);

    // busy blocks start; unknown byte
    busy = 1'b1; send("s", 2); busy = 1'b0;
    send("x", 2);
    check("idle_after_x", 64'(idle_o), 64'd1);

    // Height boundary and rank zero boundary
    send("h", 0); send(8'd4, 0); send("s", 2);
    send("h", 0); send(8'd5, 0); send("s", 1);
    send("r", 0); send(8'd0, 0); send("s", 2);
    send("r", 0); send(8'd1, 0); send("s", 1);

    // Command letters as raw argument data
    send("h", 0); send("s", 0);
    check("raw_height", 64'(height_o), 64'h73);
    send("r", 0); send("m", 0);
    check("raw_rank", 64'(rank_o), 64'h6D);
    check("raw_idle", 64'(idle_o), 64'd1);

    // Bits beyond n*n are cleared (n=5 -> 25 bits over 4 bytes)
    send("m", 0); send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0);
    check("mask25_pending", 64'(idle_o), 64'd0);
    send(8'hFF, 0);
    check("mask25", 64'(mask_o), 64'h1FF_FFFF);

    // Asynchronous reset mid-mask
    send("n", 0); send(8'd3, 0);
    send("m", 0); send(8'hAA, 0);
    check("mid_mask_busy", 64'(idle_o), 64'd0);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    check_reset_values("midrst");

`ifdef CMD_TIMEOUT_EN
    send("h", 0);
    sb_q.push_back('{2, cyc + 100});
    repeat (102) @(posedge clk);
    #1;
    check("tmo_idle", 64'(idle_o), 64'd1);
    send(8'd40, 2);
    check("tmo_height", 64'(height_o), 64'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Consumes bytes from the UART receiver (8N1, byte strobe) and parses the host command protocol for the masked 2D filter.
- Commands: 'h' (height), 'w' (width), 'n' (window size), 'r' (rank), 'm' (mask), 's' (start).
- Holds the committed configuration registers that drive the filter core, and issues a single-cycle start pulse.
- Sits between the UART receiver and the filter controller inside top_masked_2D_filter.

Parameters:
- MAX_N, 7, largest supported odd window size.
- MASK_W, MAX_N*MAX_N, mask register width in bits.
- TIMEOUT_CYCLES, 50000, idle cycles allowed between a command byte and its argument (used only with CMD_TIMEOUT_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; each high cycle is one byte, and back-to-back strobes are legal.
- busy  input  1  filter core is processing.
- height_o  output  8  image height.
- width_o  output  8  image width.
- n_o  output  4  window size (odd, 1..MAX_N).
- rank_o  output  8  1-based order-statistic rank.
- mask_o  output  MASK_W  window mask; bit i = window element i, row-major.
- start_o  output  1  one-cycle start pulse.
- err_o  output  1  one-cycle protocol error pulse.
- idle_o  output  1  FSM in IDLE.

Behaviour:
- Reset values:
  - height_o=0, width_o=0, n_o=3, rank_o=5.
  - mask_o has bits [8:0]=1 and all other bits 0.
  - start_o=0, err_o=0, idle_o=1, state=IDLE.
- Clock and reset: clk is the only clock. rst is asynchronous and active-high. Asserting rst mid-command aborts the command and restores all reset values.
- States: IDLE, GET_H, GET_W, GET_N, GET_R, GET_MASK.
- IDLE, on rx_valid:
  - 'h' goes to GET_H; 'w' goes to GET_W; 'n' goes to GET_N; 'r' goes to GET_R.
  - 'm' goes to GET_MASK with byte counter cleared and the mask shadow cleared.
  - 's' is evaluated as described below.
  - Any other byte pulses err_o and the FSM stays in IDLE.
- GET_H / GET_W, next rx_valid: byte is written to height_o / width_o, then IDLE.
- GET_R, next rx_valid: byte is written to rank_o, then IDLE. Range is not checked here.
- GET_N, next rx_valid:
  - Byte odd and in 1..MAX_N: commit n_o, then IDLE.
  - Otherwise: pulse err_o, n_o unchanged, then IDLE.
  - mask_o is not modified by an n change.
- GET_MASK:
  - Expects ceil(n_o*n_o/8) bytes, LSB-first.
  - Byte k fills shadow bits [8k+7:8k].
  - On the final byte, commit shadow to mask_o with bits >= n_o*n_o forced to 0, then IDLE.
  - Example: n=3 takes 2 bytes; 0xFF,0x01 gives mask 0x1FF.
- 's' is accepted only if all of the following hold:
  - busy=0
  - 1 <= rank_o <= n_o*n_o
  - height_o >= n_o
  - width_o >= n_o
- If accepted: start_o=1 for exactly one cycle. Otherwise: err_o=1 for one cycle and no start.
- Latency: every register update, start_o and err_o appear one cycle after the rx_valid cycle of the determining byte.
- Outputs are stable except on commit.
- idle_o is registered and equals (state==IDLE).
- Argument bytes are taken raw: a byte equal to an ASCII command letter is data in GET_* states.
- rank_o width: the n_o*n_o comparison uses 8-bit arithmetic (max 49).

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- When defined:
  - A counter runs in every non-IDLE state and is cleared on each rx_valid.
  - Reaching TIMEOUT_CYCLES pulses err_o, discards the partial command (mask shadow dropped, committed registers unchanged) and returns to IDLE.
- When undefined: no counter; the FSM waits indefinitely for argument bytes.

Test Plan:
- Reset then 'h',22,'w',22,'n',3,'r',5,'m',0xFF,0x01,'s' with busy=0:
  - height_o=22, width_o=22, n_o=3, rank_o=5, mask_o=0x1FF.
  - start_o single pulse one cycle after 's'; err_o never high.
- 'n',4 then 'n',9 (MAX_N=7): two err_o pulses; n_o stays 3. Then 'n',7, 'm' followed by 7 bytes 0xFF: mask_o has 49 ones, and the FSM returns to IDLE after byte 7 only.
- 'n',5, 'r',26, 's': err_o pulse, no start_o. Then 'r',25, 's': start_o pulse.
- 's' with busy=1: err_o pulse, no start_o. Unknown byte 'x': err_o pulse, FSM stays IDLE.
- 'm',0xAA then rst asserted for 1 ns mid-command: all outputs at reset values, and mask_o=0x1FF, not 0x0AA.
- CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: 'h' followed by no byte for 100 cycles gives an err_o pulse and idle_o=1. A subsequent byte 40 is treated as a command (err_o) and height_o is unchanged.
